// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC sequencer, ROM chip-enable and the IF/ID pipeline register.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned-fetch detection instead of target masking).
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_if,
    input  logic        stall_id,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    input  logic [31:0] rom_instr_i,
    output logic        rom_ce_o,
    output logic [31:0] pc_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_instr_o,
    output logic        id_valid_o,
    output logic        id_excp_adel_o
);

    logic        ce_reg;
    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic [31:0] id_pc_reg;
    logic [31:0] id_instr_reg;
    logic        id_valid_reg;
    logic        id_excp_reg;

    logic [31:0] branch_target;
    logic [31:0] flush_target;
    logic        fetch_misaligned;

`ifdef FETCH_ALIGN_CHECK_EN
    // Targets pass through untouched; a misaligned PC is caught at fetch instead.
    assign branch_target    = branch_target_i;
    assign flush_target     = new_pc;
    assign fetch_misaligned = ce_reg && (pc_reg[1:0] != 2'b00);
`else
    assign branch_target    = {branch_target_i[31:2], 2'b00};
    assign flush_target     = {new_pc[31:2], 2'b00};
    assign fetch_misaligned = 1'b0;
`endif

    always_comb begin
        pc_next = pc_reg;
        if (ce_reg) begin
            if (flush) begin
                pc_next = flush_target;
            end else if (stall_if) begin
                pc_next = pc_reg;
            end else if (branch_flag_i) begin
                pc_next = branch_target;
            end else begin
                pc_next = pc_reg + 32'd4;
            end
        end
    end

    // The ROM enable rises one edge after reset release, so the first fetch is RESET_PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce_reg <= 1'b0;
            pc_reg <= RESET_PC;
        end else begin
            ce_reg <= 1'b1;
            pc_reg <= pc_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_pc_reg    <= 32'h0000_0000;
            id_instr_reg <= NOP_INSTR;
            id_valid_reg <= 1'b0;
            id_excp_reg  <= 1'b0;
        end else if (flush) begin
            id_pc_reg    <= 32'h0000_0000;
            id_instr_reg <= NOP_INSTR;
            id_valid_reg <= 1'b0;
            id_excp_reg  <= 1'b0;
        end else if (stall_if && !stall_id) begin
            id_pc_reg    <= 32'h0000_0000;
            id_instr_reg <= NOP_INSTR;
            id_valid_reg <= 1'b0;
            id_excp_reg  <= 1'b0;
        end else if (!stall_id) begin
            id_pc_reg <= pc_reg;
            if (fetch_misaligned) begin
                // ROM data for a misaligned address is meaningless; pass a flagged NOP to decode.
                id_instr_reg <= NOP_INSTR;
                id_valid_reg <= 1'b1;
                id_excp_reg  <= 1'b1;
            end else begin
                id_instr_reg <= rom_instr_i;
                id_valid_reg <= ce_reg;
                id_excp_reg  <= 1'b0;
            end
        end
    end

    assign rom_ce_o       = ce_reg;
    assign pc_o           = pc_reg;
    assign id_pc_o        = id_pc_reg;
    assign id_instr_o     = id_instr_reg;
    assign id_valid_o     = id_valid_reg;
    assign id_excp_adel_o = id_excp_reg;

endmodule
